// File: rtl/uart_rx_buffer_pkg.sv
// Shared types for the UART receive buffer: the stored entry layout,
// the default FIFO depth and the capture FSM states.
package uart_rx_buffer_pkg;

  localparam int RX_FIFO_DEPTH = 16;

  typedef struct packed {
    logic       frame_err;
    logic       parity_err;
    logic [7:0] data;
  } rx_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    CAPTURE,
    ARMED
  } rxb_state_t;

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Host-side read port of the UART receive buffer: valid/pop FIFO access,
// occupancy and the overrun/error-drop status.
interface uart_rx_buffer_if #(
  parameter int CNT_W = 5
);

  logic             rd_pop;
  logic             overrun_clr;
  logic             rd_valid;
  logic [7:0]       rd_data;
  logic             rd_frame_err;
  logic             rd_parity_err;
  logic [CNT_W-1:0] count;
  logic             overrun;
  logic [7:0]       err_drops;

  modport master (
    output rd_pop, overrun_clr,
    input  rd_valid, rd_data, rd_frame_err, rd_parity_err, count, overrun, err_drops
  );

  modport slave (
    input  rd_pop, overrun_clr,
    output rd_valid, rd_data, rd_frame_err, rd_parity_err, count, overrun, err_drops
  );

endinterface

// File: rtl/uart_rx_buffer_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// Writes into a full FIFO are accepted only when a read frees a slot the same cycle.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_rd;
  logic             do_wr;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// Consumer stage behind the UART receiver: catches each completed frame,
// waits one oversample tick for the receiver outputs to settle, then queues it.
module uart_rx_buffer
  import uart_rx_buffer_pkg::*;
#(
  parameter int DEPTH        = RX_FIFO_DEPTH,
  parameter bit DROP_ERRORED = 1'b0,
  parameter int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       rx_frame_err,
  input  logic       rx_parity_err,
  uart_rx_buffer_if.slave host
);

  rxb_state_t       state;
  logic             done_meta;
  logic             done_sync;
  logic             done_prev;
  logic             done_rise;
  rx_entry_t        cap_entry;
  rx_entry_t        head_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             pop_ok;
  logic             drop_err;
  logic             wr_en;
  logic             lost;
  logic             overrun_q;
  logic [7:0]       err_drops_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_meta <= 1'b0;
      done_sync <= 1'b0;
      done_prev <= 1'b0;
    end else begin
      done_meta <= rx_done;
      done_sync <= done_meta;
      done_prev <= done_sync;
    end
  end

  assign done_rise = done_sync && !done_prev;
  assign cap_entry = {rx_frame_err, rx_parity_err, rx_data};
  assign drop_err  = DROP_ERRORED && (rx_frame_err || rx_parity_err);
  assign pop_ok    = host.rd_pop && !fifo_empty;

  // A full FIFO still accepts the frame if the host frees the head in the same cycle.
  assign wr_en = (state == CAPTURE) && !drop_err && (!fifo_full || pop_ok);
  assign lost  = (state == CAPTURE) && !drop_err && fifo_full && !pop_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      overrun_q   <= 1'b0;
      err_drops_q <= '0;
    end else begin
      case (state)
        IDLE:      if (done_rise) state <= WAIT_TICK;
        WAIT_TICK: if (tick) state <= CAPTURE;
        CAPTURE: begin
          state <= ARMED;
          if (drop_err && (err_drops_q != 8'hFF)) begin
            err_drops_q <= err_drops_q + 8'd1;
          end
        end
        ARMED:     if (!done_sync) state <= IDLE;
        default:   state <= IDLE;
      endcase
      // A fresh loss wins over a simultaneous clear so no overrun goes unreported.
      if (lost) begin
        overrun_q <= 1'b1;
      end else if (host.overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (cap_entry),
    .rd_en   (host.rd_pop),
    .rd_data (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign host.rd_valid      = !fifo_empty;
  assign host.rd_data       = head_entry.data;
  assign host.rd_frame_err  = head_entry.frame_err;
  assign host.rd_parity_err = head_entry.parity_err;
  assign host.count         = fifo_count;
  assign host.overrun       = overrun_q;
  assign host.err_drops     = err_drops_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer: one instance keeps errored frames, a second drops them;
// both see the same receiver stimulus.
module tb_uart_rx_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_frame_err = 1'b0;
  logic       rx_parity_err = 1'b0;

  int checks = 0;
  int errors = 0;
  int tick_period = 16;
  int tick_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    logic       kept;
  } frame_vec_t;

  frame_vec_t vecs [3];

  uart_rx_buffer_if h_keep ();
  uart_rx_buffer_if h_drop ();

  uart_rx_buffer #(.DROP_ERRORED(1'b0)) dut_keep (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .rx_done       (rx_done),
    .rx_data       (rx_data),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .host          (h_keep)
  );

  uart_rx_buffer #(.DROP_ERRORED(1'b1)) dut_drop (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .rx_done       (rx_done),
    .rx_data       (rx_data),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .host          (h_drop)
  );

  always #5 clk = ~clk;

  // Baud-generator stand-in: one-cycle tick every tick_period clocks.
  always @(negedge clk) begin
    if (tick_cnt >= tick_period - 1) begin
      tick_cnt = 0;
      tick     = 1'b1;
    end else begin
      tick_cnt = tick_cnt + 1;
      tick     = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Returns on the falling edge right after a clock edge that saw tick high.
  task automatic waitTick();
    @(posedge clk);
    while (tick !== 1'b1) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic fe, input logic pe);
    waitTick();
    rx_data       = data;
    rx_frame_err  = fe;
    rx_parity_err = pe;
    rx_done       = 1'b1;
    repeat (tick_period + 8) @(negedge clk);
    rx_done = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic popCheck(input bit sel, input logic [7:0] data, input logic fe, input logic pe,
                          input string tag);
    if (sel) begin
      checkOutput({tag, "_valid"}, 32'(h_drop.rd_valid), 32'd1);
      checkOutput({tag, "_data"}, 32'(h_drop.rd_data), 32'(data));
      checkOutput({tag, "_ferr"}, 32'(h_drop.rd_frame_err), 32'(fe));
      checkOutput({tag, "_perr"}, 32'(h_drop.rd_parity_err), 32'(pe));
      h_drop.rd_pop = 1'b1;
    end else begin
      checkOutput({tag, "_valid"}, 32'(h_keep.rd_valid), 32'd1);
      checkOutput({tag, "_data"}, 32'(h_keep.rd_data), 32'(data));
      checkOutput({tag, "_ferr"}, 32'(h_keep.rd_frame_err), 32'(fe));
      checkOutput({tag, "_perr"}, 32'(h_keep.rd_parity_err), 32'(pe));
      h_keep.rd_pop = 1'b1;
    end
    @(negedge clk);
    h_drop.rd_pop = 1'b0;
    h_keep.rd_pop = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int lat;
    h_keep.rd_pop = 1'b0;
    h_keep.overrun_clr = 1'b0;
    h_drop.rd_pop = 1'b0;
    h_drop.overrun_clr = 1'b0;

    vecs[0] = '{data: 8'h11, fe: 1'b0, pe: 1'b1, kept: 1'b0};
    vecs[1] = '{data: 8'h22, fe: 1'b0, pe: 1'b0, kept: 1'b1};
    vecs[2] = '{data: 8'h33, fe: 1'b1, pe: 1'b0, kept: 1'b0};

    repeat (3) @(negedge clk);
    checkOutput("rst_count", 32'(h_keep.count), 32'd0);
    checkOutput("rst_valid", 32'(h_keep.rd_valid), 32'd0);
    checkOutput("rst_overrun", 32'(h_keep.overrun), 32'd0);
    checkOutput("rst_err_drops", 32'(h_drop.err_drops), 32'd0);
    reset = 1'b0;

    // Test 1: asynchronous reset while a fourth frame waits for its tick.
    tick_period = 16;
    applyStimulus(8'h01, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b0, 1'b0);
    applyStimulus(8'h03, 1'b0, 1'b1);
    checkOutput("t1_count3", 32'(h_keep.count), 32'd3);
    waitTick();
    rx_data = 8'h99;
    rx_done = 1'b1;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("t1_async_count", 32'(h_keep.count), 32'd0);
    checkOutput("t1_async_valid", 32'(h_keep.rd_valid), 32'd0);
    checkOutput("t1_async_overrun", 32'(h_keep.overrun), 32'd0);
    checkOutput("t1_async_err_drops", 32'(h_drop.err_drops), 32'd0);
    rx_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("t1_no_stale_count", 32'(h_keep.count), 32'd0);
    checkOutput("t1_no_stale_valid", 32'(h_keep.rd_valid), 32'd0);

    // Test 2: single clean frame, latency with tick every 16 clocks, long rx_done.
    waitTick();
    rx_data       = 8'hA5;
    rx_frame_err  = 1'b0;
    rx_parity_err = 1'b0;
    rx_done       = 1'b1;
    lat = 0;
    while (!h_keep.rd_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("t2_latency", 32'(lat), 32'd17);
    repeat (100 - lat) @(negedge clk);
    rx_done = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("t2_count", 32'(h_keep.count), 32'd1);
    popCheck(1'b0, 8'hA5, 1'b0, 1'b0, "t2_pop");
    checkOutput("t2_empty", 32'(h_keep.rd_valid), 32'd0);

    // Test 3: overfill with 17 frames, drain in order, clear overrun.
    tick_period = 4;
    for (int i = 0; i <= 16; i++) applyStimulus(8'(i), 1'b0, 1'b0);
    checkOutput("t3_count_full", 32'(h_keep.count), 32'd16);
    checkOutput("t3_overrun", 32'(h_keep.overrun), 32'd1);
    for (int i = 0; i < 16; i++) popCheck(1'b0, 8'(i), 1'b0, 1'b0, "t3_pop");
    checkOutput("t3_count_empty", 32'(h_keep.count), 32'd0);
    checkOutput("t3_overrun_sticky", 32'(h_keep.overrun), 32'd1);
    h_keep.overrun_clr = 1'b1;
    @(negedge clk);
    h_keep.overrun_clr = 1'b0;
    checkOutput("t3_overrun_clr", 32'(h_keep.overrun), 32'd0);

    // Test 4: full FIFO, host pops exactly in the CAPTURE cycle of frame 0x5A.
    for (int i = 0; i < 16; i++) applyStimulus(8'(8'h20 + i), 1'b0, 1'b0);
    checkOutput("t4_count_full", 32'(h_keep.count), 32'd16);
    waitTick();
    rx_data = 8'h5A;
    rx_done = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("t4_head_before", 32'(h_keep.rd_data), 32'h20);
    h_keep.rd_pop = 1'b1;
    @(negedge clk);
    h_keep.rd_pop = 1'b0;
    checkOutput("t4_count_same", 32'(h_keep.count), 32'd16);
    checkOutput("t4_no_overrun", 32'(h_keep.overrun), 32'd0);
    repeat (tick_period + 3) @(negedge clk);
    rx_done = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 1; i < 16; i++) popCheck(1'b0, 8'(8'h20 + i), 1'b0, 1'b0, "t4_pop");
    popCheck(1'b0, 8'h5A, 1'b0, 1'b0, "t4_last");
    checkOutput("t4_overrun_end", 32'(h_keep.overrun), 32'd0);

    // Test 5: errored frames dropped by one instance, kept with flags by the other.
    doReset();
    foreach (vecs[i]) applyStimulus(vecs[i].data, vecs[i].fe, vecs[i].pe);
    checkOutput("t5_drop_count", 32'(h_drop.count), 32'd1);
    checkOutput("t5_drop_err_drops", 32'(h_drop.err_drops), 32'd2);
    checkOutput("t5_keep_count", 32'(h_keep.count), 32'd3);
    checkOutput("t5_keep_err_drops", 32'(h_keep.err_drops), 32'd0);
    foreach (vecs[i]) popCheck(1'b0, vecs[i].data, vecs[i].fe, vecs[i].pe, "t5_keep_pop");
    foreach (vecs[i]) begin
      if (vecs[i].kept) popCheck(1'b1, vecs[i].data, vecs[i].fe, vecs[i].pe, "t5_drop_pop");
    end
    checkOutput("t5_drop_empty", 32'(h_drop.rd_valid), 32'd0);

    // Test 6: err_drops saturation, then pops on an empty FIFO must not move pointers.
    doReset();
    for (int i = 0; i < 300; i++) applyStimulus(8'(i), 1'b0, 1'b1);
    checkOutput("t6_err_drops_sat", 32'(h_drop.err_drops), 32'd255);
    checkOutput("t6_drop_count", 32'(h_drop.count), 32'd0);
    checkOutput("t6_keep_count", 32'(h_keep.count), 32'd16);
    checkOutput("t6_keep_overrun", 32'(h_keep.overrun), 32'd1);
    h_drop.rd_pop = 1'b1;
    repeat (3) @(negedge clk);
    h_drop.rd_pop = 1'b0;
    checkOutput("t6_empty_pop_count", 32'(h_drop.count), 32'd0);
    checkOutput("t6_empty_pop_valid", 32'(h_drop.rd_valid), 32'd0);
    applyStimulus(8'h77, 1'b0, 1'b0);
    checkOutput("t6_after_count", 32'(h_drop.count), 32'd1);
    popCheck(1'b1, 8'h77, 1'b0, 1'b0, "t6_after_pop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
Receive-side consumer stage directly downstream of the UART receiver. Detects each completed frame on the receiver's rx_done, waits until the receiver's data/error outputs are settled, then captures data, frame_error and parity_error into a FIFO. Presents the FIFO to the host through a valid/pop interface, with occupancy and sticky overrun reporting.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2.
DROP_ERRORED, 0, 1 = frames with frame_error or parity_error are discarded instead of stored.
CNT_W, $clog2(DEPTH)+1, width of count output.

Ports:
clk  input  1  system clock; single clock domain.
reset  input  1  asynchronous, active-high reset.
tick  input  1  one-clk-wide oversample strobe from the baud generator; period is at least 3 clk cycles.
rx_done  input  1  receiver frame-complete level; updated on tick.
rx_data  input  8  receiver data_out (7-bit mode arrives zero-extended).
rx_frame_err  input  1  receiver frame_error.
rx_parity_err  input  1  receiver parity_error.
rd_pop  input  1  host consumes head entry this cycle.
overrun_clr  input  1  clears the overrun flag.
rd_valid  output  1  FIFO not empty.
rd_data  output  8  head entry data.
rd_frame_err  output  1  head entry frame error.
rd_parity_err  output  1  head entry parity error.
count  output  CNT_W  number of stored entries, 0..DEPTH.
overrun  output  1  sticky: a frame was lost because the FIFO was full.
err_drops  output  8  saturating count of frames discarded by DROP_ERRORED.

Behaviour:
- Reset (asynchronous, active-high) clears all outputs, pointers, count, overrun and err_drops to 0. Synchronizer flops and FSM return to IDLE. Reset mid-capture abandons that frame.
- rx_done passes through a 2-flop synchronizer. A rising edge of the synchronized signal is one event. The FSM does not re-arm until rx_done has been seen low.
- FSM states:
  - IDLE: on the synchronized rx_done rise, go to WAIT_TICK.
  - WAIT_TICK: on the first cycle with tick==1, go to CAPTURE.
  - CAPTURE (one cycle): sample rx_data, rx_frame_err and rx_parity_err, then perform the write decision and go to ARMED.
  - ARMED: when synchronized rx_done==0, go to IDLE.
- Write decision in CAPTURE:
  - If DROP_ERRORED=1 and either error bit is set: no write; err_drops += 1, saturating at 255.
  - Else if not full, or full with rd_pop=1 in the same cycle: write the entry.
  - Else: drop the entry and set overrun=1.
- overrun stays set until overrun_clr=1. If overrun_clr and a new overrun occur in the same cycle, overrun ends up set.
- FIFO timing:
  - First-word-fall-through: rd_data, rd_frame_err and rd_parity_err show the head entry combinationally from storage.
  - rd_valid and count update on the clk edge after a write.
- Pop rules:
  - rd_pop with rd_valid=0 is ignored; no pointer or count change.
  - Simultaneous write and pop: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full is count==DEPTH; empty is count==0.
- Latency: from the clk edge where rx_done rises to rd_valid high in an empty FIFO is 2 (sync) + 1 (edge) + wait-for-tick + 1 (capture) + 1 (write) cycles.
- Outputs when empty hold the last storage contents and are don't-care; the bench must qualify them with rd_valid.

Decomposition:
- Shared package defs: typedef rx_entry_t as packed {frame_err, parity_err, data[7:0]} (10 bits); constant RX_FIFO_DEPTH = 16; enum rxb_state_t {IDLE, WAIT_TICK, CAPTURE, ARMED}.
- One sub-module, sync_fifo:
  - Parameterized by width and depth.
  - Inputs wr_en, rd_en; outputs full, empty, count.
  - Same reset.
- uart_rx_buffer holds the synchronizer, FSM, drop/overrun logic and err_drops.

Test Plan:
1. Reset asserted mid-WAIT_TICK with 3 entries stored -> count=0, rd_valid=0, overrun=0, err_drops=0 immediately (asynchronous), no stale write after release.
2. Single frame rx_data=0xA5, no errors, tick every 16 clk -> exactly one entry; rd_data=0xA5, errs=0, rd_valid high within the stated latency; rx_done held high for 100 cycles still yields one entry.
3. 17 frames 0x00..0x10 without popping, DEPTH=16 -> count=16, 17th frame dropped, overrun=1; pop all -> sequence 0x00..0x0F in order; overrun_clr -> overrun=0.
4. FIFO full, rd_pop asserted in the CAPTURE cycle of frame 0x5A -> no overrun, count stays 16, 0x5A is last out.
5. DROP_ERRORED=1: frames 0x11 (parity_err=1), 0x22 (clean), 0x33 (frame_err=1) -> only 0x22 stored, err_drops=2; DROP_ERRORED=0 same stimulus -> 3 entries with matching error flags.
6. 300 errored frames with DROP_ERRORED=1 -> err_drops saturates at 255; pop on empty FIFO -> count stays 0, pointers unchanged.
